// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory bus between the instruction-fetch (IF)
// port and the data-access (MEM) port of the pipeline. One requester is
// granted at a time. MEM always wins in IDLE because it belongs to the older
// instruction. A stall request is raised toward ctrl until the port's data has
// been delivered. The returned data is then held until the consuming stage
// advances.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   stall[5:0]        stall vector from ctrl (bit 1 = IF held, bit 4 = MEM held)
//   if_req_i          fetch request, held with if_addr_i until stallreq_if_o=0
//   if_addr_i         fetch address
//   if_rdata_o        fetched instruction (registered)
//   stallreq_if_o     stall request for the fetch port
//   mem_req_i         data request, held with attributes until stallreq_mem_o=0
//   mem_we_i          1 = write
//   mem_sel_i         byte enables
//   mem_addr_i        data address
//   mem_wdata_i       store data
//   mem_rdata_o       load data (registered)
//   stallreq_mem_o    stall request for the data port
//   bus_cyc_o         bus transaction active
//   bus_we_o          bus write
//   bus_sel_o         bus byte enables
//   bus_addr_o        bus address
//   bus_wdata_o       bus write data
//   bus_rdata_i       bus read data, valid with bus_ack_i
//   bus_ack_i         transaction complete
// -----------------------------------------------------------------------------
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        stallreq_if_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        stallreq_mem_o,
    output logic        bus_cyc_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_D_BUSY,
        S_I_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_done_if;
    logic        r_done_mem;
    logic        r_bus_cyc;
    logic        r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    logic        w_if_elig;
    logic        w_mem_elig;
    logic        w_grant_if;
    logic        w_grant_mem;
    logic        w_ack_if;
    logic        w_ack_mem;

    // Only the IF and MEM hold bits matter here.
    logic        w_unused_stall;
    assign w_unused_stall = ^{stall[5], stall[3:2], stall[0]};

    // A port whose data has been delivered stays ineligible until its stage
    // advances, so a held request is never re-issued on the bus.
    assign w_if_elig  = if_req_i  & ~r_done_if;
    assign w_mem_elig = mem_req_i & ~r_done_mem;

    assign stallreq_if_o  = w_if_elig;
    assign stallreq_mem_o = w_mem_elig;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_mem  = 1'b0;
        w_ack_if     = 1'b0;
        w_ack_mem    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_elig) begin
                    w_state_next = S_D_BUSY;
                    w_grant_mem  = 1'b1;
                end else if (w_if_elig) begin
                    w_state_next = S_I_BUSY;
                    w_grant_if   = 1'b1;
                end
            end
            S_D_BUSY: begin
                if (bus_ack_i) begin
                    w_state_next = S_IDLE;
                    w_ack_mem    = 1'b1;
                end
            end
            S_I_BUSY: begin
                if (bus_ack_i) begin
                    w_state_next = S_IDLE;
                    w_ack_if     = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_done_if   <= 1'b0;
            r_done_mem  <= 1'b0;
        end else begin
            if (w_grant_mem) begin
                r_bus_cyc   <= 1'b1;
                r_bus_we    <= mem_we_i;
                r_bus_sel   <= mem_sel_i;
                r_bus_addr  <= mem_addr_i;
                r_bus_wdata <= mem_wdata_i;
            end else if (w_grant_if) begin
                r_bus_cyc   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= '1;
                r_bus_addr  <= if_addr_i;
                r_bus_wdata <= '0;
            end

            if (w_ack_mem || w_ack_if) begin
                r_bus_cyc <= 1'b0;
                r_bus_we  <= 1'b0;
            end

            // r_bus_we still carries the direction of the finishing transfer.
            if (w_ack_mem && !r_bus_we) begin
                r_mem_rdata <= bus_rdata_i;
            end
            if (w_ack_if) begin
                r_if_rdata <= bus_rdata_i;
            end

            // Done is set on the ack edge and clears on the first later edge
            // where the owning stage is free to advance.
            if (w_ack_if) begin
                r_done_if <= 1'b1;
            end else if (r_done_if && !stall[1]) begin
                r_done_if <= 1'b0;
            end

            if (w_ack_mem) begin
                r_done_mem <= 1'b1;
            end else if (r_done_mem && !stall[4]) begin
                r_done_mem <= 1'b0;
            end
        end
    end

    assign bus_cyc_o   = r_bus_cyc;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign if_rdata_o  = r_if_rdata;
    assign mem_rdata_o = r_mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed cycle tables for the documented scenarios, a hand-written reset
// sequence, then randomized traffic against a transaction-level model: two
// requesters with their own pending operations, a word memory, and a bus slave
// with random wait states.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        stallreq_if_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        stallreq_mem_o;
    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    mem_bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .stallreq_if_o (stallreq_if_o),
        .mem_req_i     (mem_req_i),
        .mem_we_i      (mem_we_i),
        .mem_sel_i     (mem_sel_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .stallreq_mem_o(stallreq_mem_o),
        .bus_cyc_o     (bus_cyc_o),
        .bus_we_o      (bus_we_o),
        .bus_sel_o     (bus_sel_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One row = inputs applied for one cycle + outputs expected in that cycle.
    typedef struct {
        logic [5:0]  st;
        logic        ireq;
        logic [31:0] iaddr;
        logic        mreq;
        logic        mwe;
        logic [3:0]  msel;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        ack;
        logic [31:0] rd;
        logic        ecyc;
        logic        ewe;
        logic [3:0]  esel;
        logic [31:0] eaddr;
        logic        esif;
        logic        esmem;
        logic [31:0] eifd;
        logic [31:0] ememd;
    } vec_t;

    function automatic vec_t mk(
        input logic [5:0] st, input logic ireq, input logic [31:0] iaddr,
        input logic mreq, input logic mwe, input logic [3:0] msel,
        input logic [31:0] maddr, input logic [31:0] mwd,
        input logic ack, input logic [31:0] rd,
        input logic ecyc, input logic ewe, input logic [3:0] esel,
        input logic [31:0] eaddr, input logic esif, input logic esmem,
        input logic [31:0] eifd, input logic [31:0] ememd);
        vec_t v;
        v.st = st; v.ireq = ireq; v.iaddr = iaddr; v.mreq = mreq; v.mwe = mwe;
        v.msel = msel; v.maddr = maddr; v.mwd = mwd; v.ack = ack; v.rd = rd;
        v.ecyc = ecyc; v.ewe = ewe; v.esel = esel; v.eaddr = eaddr;
        v.esif = esif; v.esmem = esmem; v.eifd = eifd; v.ememd = ememd;
        return v;
    endfunction

    vec_t tbl[$];

    // Random-phase model state
    logic [31:0] mm [16];
    logic        m_act, m_acked, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wd;
    logic        i_act, i_acked;
    logic [31:0] i_addr;
    logic [31:0] exp_ifd, exp_memd;
    logic        s_cyc, s_ack, s_melig, s_ielig;
    logic [5:0]  s_st;
    int          owner;
    int          wcnt;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [31:0] cap_addr, cap_wd;

    initial begin
        rst = 1'b1; stall = '0; if_req_i = 0; if_addr_i = '0; mem_req_i = 0;
        mem_we_i = 0; mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        bus_rdata_i = '0; bus_ack_i = 0;

        //            st     ir ia       mr mw ms     ma        mwd           ak rd             | cy we es     ea        si sm ifd            memd
        // reset state
        tbl.push_back(mk(6'h00, 0, 'h0,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'h0, 'h0,   0, 0, 'h0,          'h0));
        // single fetch, zero wait
        tbl.push_back(mk(6'h00, 1, 'h10,  0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'h0, 'h0,   1, 0, 'h0,          'h0));
        tbl.push_back(mk(6'h00, 1, 'h10,  0, 0, 4'h0, 'h0,   'h0,          1, 'h34011100,   1, 0, 4'hF, 'h10,  1, 0, 'h0,          'h0));
        tbl.push_back(mk(6'h00, 1, 'h10,  0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h10,  0, 0, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h10,  0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h10,  0, 0, 'h34011100,   'h0));
        // data write, 3 wait states
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 1, 4'h3, 'h100, 'hDEADBEEF,   0, 'h0,          0, 0, 4'hF, 'h10,  0, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 1, 4'h3, 'h100, 'hDEADBEEF,   0, 'h0,          1, 1, 4'h3, 'h100, 0, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 1, 4'h3, 'h100, 'hDEADBEEF,   0, 'h0,          1, 1, 4'h3, 'h100, 0, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 1, 4'h3, 'h100, 'hDEADBEEF,   0, 'h0,          1, 1, 4'h3, 'h100, 0, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 1, 4'h3, 'h100, 'hDEADBEEF,   1, 'h12345678,   1, 1, 4'h3, 'h100, 0, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 1, 4'h3, 'h100, 'hDEADBEEF,   0, 'h0,          0, 0, 4'h3, 'h100, 0, 0, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 0, 'h0,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'h3, 'h100, 0, 0, 'h34011100,   'h0));
        // simultaneous IF and MEM reads
        tbl.push_back(mk(6'h00, 1, 'h20,  1, 0, 4'hF, 'h200, 'h0,          0, 'h0,          0, 0, 4'h3, 'h100, 1, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 1, 'h20,  1, 0, 4'hF, 'h200, 'h0,          1, 'hAAAA5555,   1, 0, 4'hF, 'h200, 1, 1, 'h34011100,   'h0));
        tbl.push_back(mk(6'h00, 1, 'h20,  1, 0, 4'hF, 'h200, 'h0,          0, 'h0,          0, 0, 4'hF, 'h200, 1, 0, 'h34011100,   'hAAAA5555));
        tbl.push_back(mk(6'h00, 1, 'h20,  0, 0, 4'h0, 'h0,   'h0,          1, 'h01234567,   1, 0, 4'hF, 'h20,  1, 0, 'h34011100,   'hAAAA5555));
        tbl.push_back(mk(6'h00, 1, 'h20,  0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h20,  0, 0, 'h01234567,   'hAAAA5555));
        tbl.push_back(mk(6'h00, 0, 'h20,  0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h20,  0, 0, 'h01234567,   'hAAAA5555));
        // MEM read, then stage held for 3 cycles (one stray ack in IDLE)
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 0, 4'hF, 'h300, 'h0,          0, 'h0,          0, 0, 4'hF, 'h20,  0, 1, 'h01234567,   'hAAAA5555));
        tbl.push_back(mk(6'h10, 0, 'h0,   1, 0, 4'hF, 'h300, 'h0,          1, 'hCAFEF00D,   1, 0, 4'hF, 'h300, 0, 1, 'h01234567,   'hAAAA5555));
        tbl.push_back(mk(6'h10, 0, 'h0,   1, 0, 4'hF, 'h300, 'h0,          1, 'hFFFFFFFF,   0, 0, 4'hF, 'h300, 0, 0, 'h01234567,   'hCAFEF00D));
        tbl.push_back(mk(6'h10, 0, 'h0,   1, 0, 4'hF, 'h300, 'h0,          0, 'h0,          0, 0, 4'hF, 'h300, 0, 0, 'h01234567,   'hCAFEF00D));
        tbl.push_back(mk(6'h10, 0, 'h0,   1, 0, 4'hF, 'h300, 'h0,          0, 'h0,          0, 0, 4'hF, 'h300, 0, 0, 'h01234567,   'hCAFEF00D));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 0, 4'hF, 'h300, 'h0,          0, 'h0,          0, 0, 4'hF, 'h300, 0, 0, 'h01234567,   'hCAFEF00D));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 0, 4'hF, 'h304, 'h0,          0, 'h0,          0, 0, 4'hF, 'h300, 0, 1, 'h01234567,   'hCAFEF00D));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 0, 4'hF, 'h304, 'h0,          1, 'h11112222,   1, 0, 4'hF, 'h304, 0, 1, 'h01234567,   'hCAFEF00D));
        tbl.push_back(mk(6'h00, 0, 'h0,   1, 0, 4'hF, 'h304, 'h0,          0, 'h0,          0, 0, 4'hF, 'h304, 0, 0, 'h01234567,   'h11112222));
        tbl.push_back(mk(6'h00, 0, 'h0,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h304, 0, 0, 'h01234567,   'h11112222));
        // back-to-back fetches at 0x0, 0x4, 0x8
        tbl.push_back(mk(6'h00, 1, 'h0,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h304, 1, 0, 'h01234567,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h0,   0, 0, 4'h0, 'h0,   'h0,          1, 'h10000000,   1, 0, 4'hF, 'h0,   1, 0, 'h01234567,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h0,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h0,   0, 0, 'h10000000,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h4,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h0,   1, 0, 'h10000000,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h4,   0, 0, 4'h0, 'h0,   'h0,          1, 'h10000004,   1, 0, 4'hF, 'h4,   1, 0, 'h10000000,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h4,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h4,   0, 0, 'h10000004,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h8,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h4,   1, 0, 'h10000004,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h8,   0, 0, 4'h0, 'h0,   'h0,          1, 'h10000008,   1, 0, 4'hF, 'h8,   1, 0, 'h10000004,   'h11112222));
        tbl.push_back(mk(6'h00, 1, 'h8,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h8,   0, 0, 'h10000008,   'h11112222));
        tbl.push_back(mk(6'h00, 0, 'h8,   0, 0, 4'h0, 'h0,   'h0,          0, 'h0,          0, 0, 4'hF, 'h8,   0, 0, 'h10000008,   'h11112222));

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = 1'b0; stall = tbl[i].st;
            if_req_i = tbl[i].ireq; if_addr_i = tbl[i].iaddr;
            mem_req_i = tbl[i].mreq; mem_we_i = tbl[i].mwe; mem_sel_i = tbl[i].msel;
            mem_addr_i = tbl[i].maddr; mem_wdata_i = tbl[i].mwd;
            bus_ack_i = tbl[i].ack; bus_rdata_i = tbl[i].rd;
            @(negedge clk);
            chk1($sformatf("row%0d cyc", i), bus_cyc_o, tbl[i].ecyc);
            chk1($sformatf("row%0d we", i), bus_we_o, tbl[i].ewe);
            chk32($sformatf("row%0d sel", i), 32'(bus_sel_o), 32'(tbl[i].esel));
            chk32($sformatf("row%0d addr", i), bus_addr_o, tbl[i].eaddr);
            if (tbl[i].ewe) chk32($sformatf("row%0d wdata", i), bus_wdata_o, tbl[i].mwd);
            chk1($sformatf("row%0d stallreq_if", i), stallreq_if_o, tbl[i].esif);
            chk1($sformatf("row%0d stallreq_mem", i), stallreq_mem_o, tbl[i].esmem);
            chk32($sformatf("row%0d if_rdata", i), if_rdata_o, tbl[i].eifd);
            chk32($sformatf("row%0d mem_rdata", i), mem_rdata_o, tbl[i].ememd);
            @(posedge clk);
            #1;
        end

        // Reset while a fetch is on the bus, then a late ack.
        if_req_i = 1; if_addr_i = 32'h40; bus_ack_i = 0;
        @(negedge clk);
        chk1("rst_seq req stallreq_if", stallreq_if_o, 1'b1);
        chk1("rst_seq req cyc", bus_cyc_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_seq busy cyc", bus_cyc_o, 1'b1);
        chk32("rst_seq busy addr", bus_addr_o, 32'h40);
        @(posedge clk); #1;
        rst = 1'b0; if_req_i = 0; bus_ack_i = 1; bus_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        chk1("rst_seq edge cyc", bus_cyc_o, 1'b0);
        chk32("rst_seq edge addr", bus_addr_o, 32'h0);
        chk32("rst_seq edge if_rdata", if_rdata_o, 32'h0);
        chk32("rst_seq edge mem_rdata", mem_rdata_o, 32'h0);
        @(posedge clk); #1;
        bus_ack_i = 0;
        @(negedge clk);
        chk1("rst_seq late ack cyc", bus_cyc_o, 1'b0);
        chk32("rst_seq late ack if_rdata", if_rdata_o, 32'h0);
        chk1("rst_seq late ack stallreq_if", stallreq_if_o, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 16; k++) mm[k] = $urandom;
        m_act = 0; m_acked = 0; m_we = 0; m_sel = 4'hF; m_addr = '0; m_wd = '0;
        i_act = 0; i_acked = 0; i_addr = '0;
        exp_ifd = '0; exp_memd = '0;
        s_cyc = bus_cyc_o; s_ack = bus_ack_i; s_melig = 0; s_ielig = 0; s_st = stall;
        owner = 0; wcnt = 0;
        cap_we = 0; cap_sel = '0; cap_addr = '0; cap_wd = '0;

        for (int c = 0; c < 3200; c++) begin
            bit   draining;
            bit   newg;
            logic a;
            logic [31:0] rd;
            logic [5:0]  st;
            draining = (c >= 3000);
            if (draining && !m_act && !i_act && !s_cyc) break;
            newg = 0;
            @(posedge clk); #1;

            // Stage advance takes effect on the edge after the data was seen.
            if (m_act && m_acked && !s_st[4]) m_act = 0;
            if (i_act && i_acked && !s_st[1]) i_act = 0;

            if (s_cyc && s_ack) begin
                chk1("rnd gap cyc", bus_cyc_o, 1'b0);
                chk1("rnd ack we", bus_we_o, 1'b0);
                if (owner == 1) begin
                    m_acked = 1;
                    if (m_we) begin
                        for (int b = 0; b < 4; b++)
                            if (m_sel[b]) mm[m_addr[5:2]][8*b +: 8] = m_wd[8*b +: 8];
                    end else begin
                        exp_memd = mm[m_addr[5:2]];
                    end
                end else if (owner == 2) begin
                    i_acked = 1;
                    exp_ifd = mm[i_addr[5:2]];
                end
                owner = 0;
            end else if (s_cyc) begin
                chk1("rnd hold cyc", bus_cyc_o, 1'b1);
                chk32("rnd hold addr", bus_addr_o, cap_addr);
                chk1("rnd hold we", bus_we_o, cap_we);
                chk32("rnd hold sel", 32'(bus_sel_o), 32'(cap_sel));
                if (cap_we) chk32("rnd hold wdata", bus_wdata_o, cap_wd);
            end else begin
                chk1("rnd grant", bus_cyc_o, s_melig || s_ielig);
                if (bus_cyc_o) begin
                    newg = 1;
                    cap_we = bus_we_o; cap_sel = bus_sel_o;
                    cap_addr = bus_addr_o; cap_wd = bus_wdata_o;
                    wcnt = int'($urandom_range(0, 3));
                    if (s_melig) begin
                        owner = 1;
                        chk32("rnd mem grant addr", bus_addr_o, m_addr);
                        chk1("rnd mem grant we", bus_we_o, m_we);
                        chk32("rnd mem grant sel", 32'(bus_sel_o), 32'(m_sel));
                        if (m_we) chk32("rnd mem grant wdata", bus_wdata_o, m_wd);
                    end else if (s_ielig) begin
                        owner = 2;
                        chk32("rnd if grant addr", bus_addr_o, i_addr);
                        chk1("rnd if grant we", bus_we_o, 1'b0);
                        chk32("rnd if grant sel", 32'(bus_sel_o), 32'hF);
                    end
                end
            end

            if (!m_act && !draining && ($urandom % 2 == 0)) begin
                m_act = 1; m_acked = 0;
                m_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                m_we = 1'($urandom % 2);
                m_sel = m_we ? 4'($urandom_range(1, 15)) : 4'hF;
                m_wd = $urandom;
            end
            if (!i_act && !draining && ($urandom % 2 == 0)) begin
                i_act = 1; i_acked = 0;
                i_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            end
            mem_req_i = m_act; mem_we_i = m_we; mem_sel_i = m_sel;
            mem_addr_i = m_addr; mem_wdata_i = m_wd;
            if_req_i = i_act; if_addr_i = i_addr;

            st = 6'($urandom);
            st[4] = !draining && ($urandom % 4 == 0);
            st[1] = !draining && ($urandom % 4 == 0);
            stall = st;

            if (bus_cyc_o) begin
                if (!newg) wcnt--;
                a = (wcnt <= 0);
                rd = bus_we_o ? $urandom : mm[bus_addr_o[5:2]];
            end else begin
                a = !draining && ($urandom % 8 == 0);
                rd = $urandom;
            end
            bus_ack_i = a; bus_rdata_i = rd;

            @(negedge clk);
            chk1("rnd stallreq_if", stallreq_if_o, i_act && !i_acked);
            chk1("rnd stallreq_mem", stallreq_mem_o, m_act && !m_acked);
            chk32("rnd if_rdata", if_rdata_o, exp_ifd);
            chk32("rnd mem_rdata", mem_rdata_o, exp_memd);
            s_cyc = bus_cyc_o; s_ack = a; s_st = st;
            s_melig = m_act && !m_acked;
            s_ielig = i_act && !i_acked;
        end

        n_checks++;
        if (m_act || i_act || s_cyc) begin
            n_fail++;
            $display("FAIL drain_timeout: mem_pending=%b if_pending=%b cyc=%b expected all 0", m_act, i_act, s_cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
